// File: rtl/seven_seg_scroller.sv
// Six-digit 7-segment message scroller: stores up to MSG_DEPTH character codes
// and scrolls them right-to-left across disp5..disp0 at SCROLL_HZ.
module seven_seg_scroller #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCROLL_HZ = 4,
  parameter int MSG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_char,
  input  logic       wr_last,
  input  logic       start,
  input  logic       stop,
  output logic       busy,
  output logic [4:0] msg_len,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5
);

  localparam int DIV   = CLK_HZ / SCROLL_HZ;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
  localparam logic [4:0]       LAST_LEN = 5'(MSG_DEPTH - 1);
  localparam logic [4:0]       CH_BLANK = 5'h10;
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    LOADING,
    READY,
    SCROLL
  } state_t;

  state_t state, state_nxt;

  logic [4:0]       msg_buf [MSG_DEPTH];
  logic [4:0]       pos;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       seq_len;
  logic [5:0]       idx;
  logic [6:0]       seg_nxt [6];
  logic [6:0]       disp_q  [6];
  logic             wr_fire;
  logic             tick;
  logic             pos_wrap;
  logic             enter_scroll;
  logic             show;

  // Segment patterns, active-low, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] enc(input logic [4:0] c);
    logic [6:0] s;
    case (c)
      5'h00:   s = 7'b1000000;
      5'h01:   s = 7'b1111001;
      5'h02:   s = 7'b0100100;
      5'h03:   s = 7'b0110000;
      5'h04:   s = 7'b0011001;
      5'h05:   s = 7'b0010010;
      5'h06:   s = 7'b0000010;
      5'h07:   s = 7'b1111000;
      5'h08:   s = 7'b0000000;
      5'h09:   s = 7'b0011000;
      5'h0A:   s = 7'b0001000;
      5'h0B:   s = 7'b0000011;
      5'h0C:   s = 7'b1000110;
      5'h0D:   s = 7'b0100001;
      5'h0E:   s = 7'b0000110;
      5'h0F:   s = 7'b0001110;
      5'h11:   s = 7'b0111111;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Six leading blanks precede the stored text in the virtual scroll sequence
  function automatic logic [4:0] seq_char(input logic [5:0] i);
    logic [5:0] off;
    logic [4:0] c;
    off = i - 6'd6;
    if (i < 6'd6) c = CH_BLANK;
    else          c = msg_buf[off[IDX_W-1:0]];
    return c;
  endfunction

  assign wr_ready     = (state != SCROLL);
  assign busy         = (state == SCROLL);
  assign wr_fire      = wr_valid && (state != SCROLL);
  assign tick         = (state == SCROLL) && (div_cnt == DIV_MAX);
  assign seq_len      = {1'b0, msg_len} + 6'd6;
  assign pos_wrap     = ({1'b0, pos} == (seq_len - 6'd1));
  assign enter_scroll = (state != SCROLL) && (state_nxt == SCROLL);
  assign show         = (state == SCROLL) && (state_nxt == SCROLL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A write takes priority over start; stop beats start everywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: begin
        if (wr_fire)
          state_nxt = (wr_last || MSG_DEPTH == 1) ? READY : LOADING;
        else if (state == READY && start && !stop)
          state_nxt = SCROLL;
      end
      LOADING: begin
        if (wr_fire && (wr_last || msg_len == LAST_LEN))
          state_nxt = READY;
      end
      SCROLL: begin
        if (stop) state_nxt = READY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (state == LOADING) msg_buf[msg_len[IDX_W-1:0]] <= wr_char;
      else                  msg_buf[0] <= wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_len <= '0;
      pos     <= '0;
      div_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (state == LOADING) msg_len <= msg_len + 5'd1;
        else                  msg_len <= 5'd1;
      end
      if (enter_scroll) begin
        pos     <= '0;
        div_cnt <= '0;
      end else if (state == SCROLL) begin
        if (tick) begin
          div_cnt <= '0;
          pos     <= pos_wrap ? 5'd0 : pos + 5'd1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
      end
    end
  end

  // Window of six characters starting at pos, wrapping modulo the sequence length
  always_comb begin
    idx     = '0;
    seg_nxt = '{default: SEG_BLANK};
    for (int k = 0; k < 6; k++) begin
      idx = {1'b0, pos} + 6'(k);
      if (idx >= seq_len) idx = idx - seq_len;
      seg_nxt[5-k] = enc(seq_char(idx));
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !show) disp_q <= '{default: SEG_BLANK};
    else                disp_q <= seg_nxt;
  end

  assign disp0 = disp_q[0];
  assign disp1 = disp_q[1];
  assign disp2 = disp_q[2];
  assign disp3 = disp_q[3];
  assign disp4 = disp_q[4];
  assign disp5 = disp_q[5];

endmodule
